// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings and transition function.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_e;

  // Saturating step toward the resolved outcome.
  function automatic bp_state_e bp_next(input bp_state_e cur, input logic taken);
    bp_state_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic bp_is_mispred(input logic upd_valid, input logic taken,
                                         input logic pred);
    return upd_valid && (taken != pred);
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Lookup, update and misprediction-counter signals of the branch history table.
interface bht_predictor_if
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 8
);

  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             pred_valid;
  logic             pred_taken;
  bp_state_e        pred_state;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_pred;

  logic             cnt_clr;
  logic [CNT_W-1:0] mispred_cnt;
  logic             mispred_sat;

  modport master (
    output req_valid, req_idx, upd_valid, upd_idx, upd_taken, upd_pred, cnt_clr,
    input  pred_valid, pred_taken, pred_state, mispred_cnt, mispred_sat
  );

  modport slave (
    input  req_valid, req_idx, upd_valid, upd_idx, upd_taken, upd_pred, cnt_clr,
    output pred_valid, pred_taken, pred_state, mispred_cnt, mispred_sat
  );

endinterface

// File: rtl/bp_cnt_sat.sv
// Saturating up-counter with synchronous clear; clear dominates increment.
module bp_cnt_sat #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_sat_c = w_sat;

endmodule

// File: rtl/bht_predictor.sv
// Flop-based table of 2-bit saturating predictors with a 1-cycle lookup,
// same-index update bypass, and a saturating misprediction counter.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  bht_predictor_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  bp_state_e        r_table [DEPTH];
  logic             r_pred_valid;
  bp_state_e        r_pred_state;

  bp_state_e        w_upd_next;
  bp_state_e        w_lookup;
  logic             w_hit;
  logic             w_mispred;
  logic [CNT_W-1:0] w_cnt;
  logic             w_sat;

  // A lookup that collides with this cycle's update sees the post-update value.
  always_comb begin
    w_upd_next = bp_next(r_table[bus.upd_idx], bus.upd_taken);
    w_hit      = bus.upd_valid && (bus.upd_idx == bus.req_idx);
    w_lookup   = w_hit ? w_upd_next : r_table[bus.req_idx];
    w_mispred  = bp_is_mispred(bus.upd_valid, bus.upd_taken, bus.upd_pred);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_table[i] <= SNT;
      end
    end else if (bus.upd_valid) begin
      r_table[bus.upd_idx] <= w_upd_next;
    end
  end

  // Response payload holds while no lookup is requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_pred_state <= SNT;
    end else begin
      r_pred_valid <= bus.req_valid;
      if (bus.req_valid) begin
        r_pred_state <= w_lookup;
      end
    end
  end

  bp_cnt_sat #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.cnt_clr),
    .i_inc   (w_mispred),
    .o_cnt   (w_cnt),
    .o_sat_c (w_sat)
  );

  assign bus.pred_valid  = r_pred_valid;
  assign bus.pred_state  = r_pred_state;
  assign bus.pred_taken  = r_pred_state[1];
  assign bus.mispred_cnt = w_cnt;
  assign bus.mispred_sat = w_sat;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: default instance plus a CNT_W=2 instance for saturation.
module tb_bht_predictor;
  import bp_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bht_predictor_if #(.IDX_W(2), .CNT_W(8)) if_a ();
  bht_predictor_if #(.IDX_W(2), .CNT_W(2)) if_b ();

  bht_predictor #(.IDX_W(2), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  bht_predictor #(.IDX_W(2), .CNT_W(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    if_a.req_valid = 1'b0; if_a.req_idx   = '0;
    if_a.upd_valid = 1'b0; if_a.upd_idx   = '0;
    if_a.upd_taken = 1'b0; if_a.upd_pred  = 1'b0;
    if_a.cnt_clr   = 1'b0;
  endtask

  task automatic idle_b();
    if_b.req_valid = 1'b0; if_b.req_idx   = '0;
    if_b.upd_valid = 1'b0; if_b.upd_idx   = '0;
    if_b.upd_taken = 1'b0; if_b.upd_pred  = 1'b0;
    if_b.cnt_clr   = 1'b0;
  endtask

  task automatic look_a(input logic [1:0] idx);
    if_a.req_valid = 1'b1; if_a.req_idx = idx;
  endtask

  task automatic upd_a(input logic [1:0] idx, input logic t, input logic p);
    if_a.upd_valid = 1'b1; if_a.upd_idx = idx; if_a.upd_taken = t; if_a.upd_pred = p;
  endtask

  task automatic upd_b(input logic [1:0] idx, input logic t, input logic p);
    if_b.upd_valid = 1'b1; if_b.upd_idx = idx; if_b.upd_taken = t; if_b.upd_pred = p;
  endtask

  initial begin
    logic [1:0] walk_exp [4];
    logic [1:0] tbl_exp  [4];
    logic [1:0] sat_cnt  [5];
    logic       sat_flag [5];
    walk_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
    tbl_exp  = '{2'd3, 2'd3, 2'd0, 2'd2};
    sat_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sat_flag = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle_a();
    idle_b();

    // Reset state
    #12;
    chk("rst_pv",    32'(if_a.pred_valid),  32'd0);
    chk("rst_ps",    32'(if_a.pred_state),  32'd0);
    chk("rst_pt",    32'(if_a.pred_taken),  32'd0);
    chk("rst_cnt",   32'(if_a.mispred_cnt), 32'd0);
    chk("rst_cnt_b", 32'(if_b.mispred_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // First lookup after reset
    look_a(2'd2); tick();
    chk("l2_pv",  32'(if_a.pred_valid),  32'd1);
    chk("l2_ps",  32'(if_a.pred_state),  32'd0);
    chk("l2_pt",  32'(if_a.pred_taken),  32'd0);
    chk("l2_cnt", 32'(if_a.mispred_cnt), 32'd0);
    idle_a(); tick();
    chk("drop_pv", 32'(if_a.pred_valid), 32'd0);
    chk("hold_ps", 32'(if_a.pred_state), 32'd0);

    // Walk idx 1 up with mispredicted taken updates, observed through the bypass
    look_a(2'd1); tick();
    chk("walk0", 32'(if_a.pred_state), 32'd0);
    for (int k = 0; k < 4; k++) begin
      look_a(2'd1); upd_a(2'd1, 1'b1, 1'b0); tick();
      chk($sformatf("walk%0d", k + 1), 32'(if_a.pred_state), 32'(walk_exp[k]));
      chk($sformatf("walk_cnt%0d", k + 1), 32'(if_a.mispred_cnt), 32'(k + 1));
    end
    idle_a(); look_a(2'd1); tick();
    chk("w_ps",  32'(if_a.pred_state),  32'd3);
    chk("w_pt",  32'(if_a.pred_taken),  32'd1);
    chk("w_cnt", 32'(if_a.mispred_cnt), 32'd4);
    chk("w_sat", 32'(if_a.mispred_sat), 32'd0);

    // Drive idx 3 to ST while looking up a different index
    idle_a(); upd_a(2'd3, 1'b1, 1'b1); look_a(2'd1); tick();
    chk("diff_idx", 32'(if_a.pred_state), 32'd3);
    idle_a(); upd_a(2'd3, 1'b1, 1'b1); tick();
    upd_a(2'd3, 1'b1, 1'b1); tick();
    upd_a(2'd3, 1'b0, 1'b1); look_a(2'd3); tick();
    chk("byp_ps",  32'(if_a.pred_state),  32'd2);
    chk("byp_pt",  32'(if_a.pred_taken),  32'd1);
    chk("byp_cnt", 32'(if_a.mispred_cnt), 32'd5);

    // Correct predictions on alternating indices leave the counter alone
    idle_a();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) upd_a(2'd0, 1'b1, 1'b1);
      else            upd_a(2'd2, 1'b0, 1'b0);
      tick();
      chk($sformatf("alt_cnt%0d", i), 32'(if_a.mispred_cnt), 32'd5);
    end
    idle_a();
    for (int i = 0; i < 4; i++) begin
      look_a(2'(i)); tick();
      chk($sformatf("tbl%0d", i), 32'(if_a.pred_state), 32'(tbl_exp[i]));
    end

    // Mid-operation reset with a lookup in flight and an update pending
    idle_a(); upd_a(2'd0, 1'b0, 1'b0); tick();
    idle_a(); look_a(2'd0); tick();
    chk("pre_rst_pv", 32'(if_a.pred_valid), 32'd1);
    chk("pre_rst_ps", 32'(if_a.pred_state), 32'd2);
    look_a(2'd0); upd_a(2'd1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_pv",  32'(if_a.pred_valid),  32'd0);
    chk("mrst_ps",  32'(if_a.pred_state),  32'd0);
    chk("mrst_pt",  32'(if_a.pred_taken),  32'd0);
    chk("mrst_cnt", 32'(if_a.mispred_cnt), 32'd0);
    tick();
    rst = 1'b0;
    idle_a(); look_a(2'd0); tick();
    chk("post_rst_pv", 32'(if_a.pred_valid), 32'd1);
    chk("post_rst_ps0", 32'(if_a.pred_state), 32'd0);
    for (int i = 1; i < 4; i++) begin
      look_a(2'(i)); tick();
      chk($sformatf("post_rst_ps%0d", i), 32'(if_a.pred_state), 32'd0);
    end
    chk("post_rst_cnt", 32'(if_a.mispred_cnt), 32'd0);

    // Clear beats a simultaneous mispredict and leaves the table untouched
    idle_a(); upd_a(2'd2, 1'b1, 1'b0); tick();
    upd_a(2'd2, 1'b1, 1'b0); tick();
    chk("a_cnt2", 32'(if_a.mispred_cnt), 32'd2);
    upd_a(2'd2, 1'b1, 1'b0); if_a.cnt_clr = 1'b1; tick();
    chk("a_clr", 32'(if_a.mispred_cnt), 32'd0);
    idle_a(); look_a(2'd2); tick();
    chk("a_clr_tbl", 32'(if_a.pred_state), 32'd3);
    idle_a();

    // Narrow counter saturation
    for (int k = 0; k < 5; k++) begin
      upd_b(2'd1, 1'b1, 1'b0); tick();
      chk($sformatf("b_cnt%0d", k), 32'(if_b.mispred_cnt), 32'(sat_cnt[k]));
      chk($sformatf("b_sat%0d", k), 32'(if_b.mispred_sat), 32'(sat_flag[k]));
    end
    upd_b(2'd1, 1'b0, 1'b1); if_b.cnt_clr = 1'b1; tick();
    chk("b_clr_cnt", 32'(if_b.mispred_cnt), 32'd0);
    chk("b_clr_sat", 32'(if_b.mispred_sat), 32'd0);
    idle_b(); if_b.req_valid = 1'b1; if_b.req_idx = 2'd1; tick();
    chk("b_tbl", 32'(if_b.pred_state), 32'd2);
    idle_b(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 Parameter IDX_W, default 2, table index width; table depth = 2**IDX_W entries.
REQ-002 Parameter CNT_W, default 8, misprediction counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  prediction lookup request.
REQ-006 req_idx  input  IDX_W  entry to look up.
REQ-007 pred_valid  output  1  registered lookup response valid.
REQ-008 pred_taken  output  1  predicted direction (1 = taken).
REQ-009 pred_state  output  2  2-bit counter value behind the prediction.
REQ-010 upd_valid  input  1  resolved-branch update strobe.
REQ-011 upd_idx  input  IDX_W  entry to update.
REQ-012 upd_taken  input  1  actual branch outcome.
REQ-013 upd_pred  input  1  direction predicted earlier for this branch.
REQ-014 cnt_clr  input  1  synchronous clear of the misprediction counter.
REQ-015 mispred_cnt  output  CNT_W  saturating misprediction count.
REQ-016 mispred_sat  output  1  high while mispred_cnt is all ones.

Function
REQ-017 Each entry SHALL be a 2-bit saturating FSM: SNT=00, WNT=01, WT=10, ST=11.
REQ-018 On upd_valid with upd_taken=1: SNT->WNT, WNT->WT, WT->ST, ST->ST.
REQ-019 On upd_valid with upd_taken=0: ST->WT, WT->WNT, WNT->SNT, SNT->SNT.
REQ-020 Entries not addressed by a valid update SHALL hold their value.
REQ-021 Lookup latency SHALL be 1 cycle: pred_valid = req_valid registered; pred_state = entry[req_idx] registered; pred_taken = pred_state[1].
REQ-022 When req_valid is low, pred_valid SHALL drop next cycle, and pred_state/pred_taken SHALL hold their last values.
REQ-023 If req_valid and upd_valid target the same index in one cycle, the response SHALL carry the post-update value (bypass).
REQ-024 If they target different indices, both SHALL complete in that cycle with no interaction.
REQ-025 A misprediction is upd_valid=1 with upd_taken != upd_pred; each one SHALL increment mispred_cnt by 1 on the next edge.
REQ-026 mispred_cnt SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-027 mispred_sat SHALL be combinational from mispred_cnt.
REQ-028 cnt_clr SHALL zero mispred_cnt next edge; clear SHALL win over a simultaneous increment.
REQ-029 cnt_clr SHALL NOT affect table entries.
REQ-030 Updates SHALL be accepted every cycle, with no stall or backpressure.

Reset
REQ-031 While rst is high, all entries SHALL be SNT, pred_valid=0, pred_taken=0, pred_state=00, mispred_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight lookup response and any update presented in that cycle.
REQ-033 After rst deasserts, the first edge SHALL operate normally.

Structure
REQ-034 The state encodings SNT/WNT/WT/ST, and the next-state function as a function, SHALL live in a shared package bp_pkg.
REQ-035 One sub-module, bp_cnt_sat (CNT_W-wide saturating counter with clear and increment), SHALL implement the misprediction counter.
REQ-036 The table SHALL be flop-based, with no RAM macro.

Verification
REQ-037 Reset, then req idx 2 -> one cycle later pred_valid=1, pred_state=00, pred_taken=0, mispred_cnt=0.
REQ-038 Four updates to idx 1, taken=1, pred=0 -> idx 1 walks 00,01,10,11,11; lookup returns pred_taken=1; mispred_cnt=4.
REQ-039 Entry idx 3 at ST, then update taken=0 and req idx 3 in the same cycle -> response pred_state=10, pred_taken=1 (bypass).
REQ-040 CNT_W=2: five mispredicts -> count 1,2,3,3,3 with mispred_sat=1 from the third; then cnt_clr together with a mispredict -> count 0.
REQ-041 Entry idx 0 at WT with a lookup in flight; assert rst -> pred_valid=0 and all entries SNT; the next lookup of idx 0 returns 00.
REQ-042 Updates with upd_taken=upd_pred, alternating indices, for 20 cycles -> mispred_cnt unchanged, and only addressed entries change.
